// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame packer: state encoding,
// frame geometry, default header bytes and the frame checksum helper.
package uart_frame_pkg;

  localparam int unsigned FRAME_LEN = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned GAP_W     = 16;
  localparam int unsigned ACK_W     = 8;
  localparam int unsigned CHK_W     = 10;

  localparam logic [BYTE_W-1:0] HDR0_DEFAULT = 8'h55;
  localparam logic [BYTE_W-1:0] HDR1_DEFAULT = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } sample_t;

  // Wide accumulator so the carry out of the byte sum is simply discarded.
  function automatic logic [BYTE_W-1:0] frame_chk(input logic [BYTE_W-1:0] h0,
                                                  input logic [BYTE_W-1:0] h1,
                                                  input sample_t           smp);
    logic [CHK_W-1:0] acc;
    acc = CHK_W'(h0) + CHK_W'(h1) + CHK_W'(smp.hi) + CHK_W'(smp.lo);
    return acc[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/uart_frame_packer.sv
// Packs a 16-bit sample into a 5-byte header/data/checksum frame and feeds it
// byte by byte to a UART transmitter using a start/busy handshake.
module uart_frame_packer
  import uart_frame_pkg::*;
#(
  parameter logic [BYTE_W-1:0] HDR0        = HDR0_DEFAULT,
  parameter logic [BYTE_W-1:0] HDR1        = HDR1_DEFAULT,
  parameter logic [GAP_W-1:0]  GAP_CYCLES  = 16'd0,
  parameter logic [ACK_W-1:0]  ACK_TIMEOUT = 8'd8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              tx_busy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned GAPX_W = GAP_W + 1;
  localparam int unsigned ACKX_W = ACK_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  sample_t           smp_q, smp_d;
  logic [BYTE_W-1:0] chk_q, chk_d;
  logic              pend_vld_q, pend_vld_d;
  sample_t           pend_q, pend_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              overrun_q, overrun_d;
  logic              tx_start_q, frame_busy_q, frame_done_q;

  logic              gap_done;
  logic              ack_done;
  logic              consume;

  function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0]  idx,
                                                   input sample_t           smp,
                                                   input logic [BYTE_W-1:0] chk);
    logic [BYTE_W-1:0] b;
    case (idx)
      IDX_W'(0): b = HDR0;
      IDX_W'(1): b = HDR1;
      IDX_W'(2): b = smp.hi;
      IDX_W'(3): b = smp.lo;
      default:   b = chk;
    endcase
    return b;
  endfunction

  assign gap_done = (GAPX_W'(gap_q) + GAPX_W'(1)) >= GAPX_W'(GAP_CYCLES);
  assign ack_done = (ACKX_W'(ack_q) + ACKX_W'(1)) >= ACKX_W'(ACK_TIMEOUT);
  // The pending sample is taken only on the cycle LOAD actually proceeds.
  assign consume  = (state_q == ST_LOAD) && !tx_busy;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    ack_d      = ack_q;
    smp_d      = smp_q;
    chk_d      = chk_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    tx_data_d  = tx_data_q;
    overrun_d  = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (data_valid || pend_vld_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (consume) begin
          smp_d      = pend_q;
          chk_d      = frame_chk(HDR0, HDR1, pend_q);
          idx_d      = '0;
          pend_vld_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        ack_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy || ack_done) state_d = ST_WAIT_DONE;
        else                     ack_d   = ack_q + ACK_W'(1);
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // Once the gap has elapsed, a held-off START waits here for tx_busy low.
        if (!gap_done) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else if (!tx_busy) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_START;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_START) tx_data_d = frame_byte(idx_d, smp_d, chk_d);

    // Every strobe lands in the one-deep pending slot; a live unconsumed entry is lost.
    if (data_valid) begin
      if (pend_vld_q && !consume) overrun_d = 1'b1;
      pend_d     = data_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      ack_q        <= '0;
      smp_q        <= '0;
      chk_q        <= '0;
      pend_vld_q   <= 1'b0;
      pend_q       <= '0;
      tx_data_q    <= '0;
      overrun_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      ack_q        <= ack_d;
      smp_q        <= smp_d;
      chk_q        <= chk_d;
      pend_vld_q   <= pend_vld_d;
      pend_q       <= pend_d;
      tx_data_q    <= tx_data_d;
      overrun_q    <= overrun_d;
      tx_start_q   <= (state_d == ST_START);
      frame_busy_q <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_DONE);
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Randomized bench for uart_frame_packer: a UART busy model, a byte monitor
// and a frame-level reference model built from the header/checksum rules.
module tb_uart_frame_packer;

  localparam logic [7:0] H0     = 8'h55;
  localparam logic [7:0] H1     = 8'hAA;
  localparam int         GAP    = 100;
  localparam int         ACK_TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        frame_busy;
  logic        frame_done;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   n_start = 0;
  int   n_done  = 0;
  int   cyc     = 0;
  bit   busy_en = 1'b1;

  uart_frame_packer #(.GAP_CYCLES(16'd100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got_v, exp_v, $time);
    end
  endtask

  // Transmitter stand-in: busy rises 1-3 clocks after a start, stays 3-20 clocks.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tx_start && busy_en) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2 tx_busy = 1'b1;
        repeat ($urandom_range(3, 20)) @(posedge clk);
        #2 tx_busy = 1'b0;
      end
    end
  end

  // Byte monitor with per-byte handshake timing checks.
  int         mon_idx   = 0;
  int         t_fall    = 0;
  int         t_start   = 0;
  bit         hold_ok   = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic       busy_prev = 1'b0;
  logic       start_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_idx = 0;
      hold_ok = 1'b0;
      got_q.delete();
    end else begin
      if (busy_prev && !tx_busy) begin
        t_fall = cyc;
        if (hold_ok) check("tx_hold", 32'(tx_data), 32'(last_byte));
      end
      if (frame_done) n_done++;
      if (tx_start) begin
        check("start_while_busy", 32'(tx_busy), 32'd0);
        check("start_pulse", 32'(start_prev), 32'd0);
        check("start_fbusy", 32'(frame_busy), 32'd1);
        if (mon_idx != 0) begin
          // busy-low cycle through START cycle, inclusive
          if (busy_en) check("gap_latency", 32'(cyc - t_fall + 1), 32'(GAP + 2));
          else         check("ack_timeout_spacing", 32'(cyc - t_start), 32'(1 + ACK_TO + 1 + GAP));
        end
        got_q.push_back(tx_data);
        last_byte = tx_data;
        hold_ok   = 1'b1;
        t_start   = cyc;
        n_start++;
        mon_idx = (mon_idx == 4) ? 0 : mon_idx + 1;
      end
    end
    busy_prev  = tx_busy;
    start_prev = tx_start;
  end

  // Reference frame: headers, sample bytes, byte-sum checksum mod 256.
  task automatic push_frame(input logic [15:0] s);
    int sum;
    sum = int'(H0) + int'(H1) + int'(s[15:8]) + int'(s[7:0]);
    exp_q.push_back(H0);
    exp_q.push_back(H1);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [15:0] d);
    @(negedge clk);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = 16'($urandom);
  endtask

  task automatic wait_done(input int target);
    int c = 0;
    while (n_done < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("frame_done_count", 32'(n_done), 32'(target));
  endtask

  task automatic wait_starts(input int target);
    int c = 0;
    while (n_start < target && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("start_reached", 32'(n_start >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"},    32'(tx_data),    32'd0);
    check({tag, "_tx_start"},   32'(tx_start),   32'd0);
    check({tag, "_frame_busy"}, 32'(frame_busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_overrun"},    32'(overrun),    32'd0);
  endtask

  initial begin
    int          d0;
    int          base;
    int          k;
    int          nf;
    int          c;
    bit          ov_exp;
    logic [15:0] s1;
    logic [15:0] sk;

    rst_n      = 1'b0;
    data_in    = 16'h0000;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known sample values with hand-derived checksums 45 and FD
    d0 = n_done; push_frame(16'h1234); send(16'h1234); wait_done(d0 + 1); compare_frames("f1234");
    check("idle_fbusy", 32'(frame_busy), 32'd0);
    d0 = n_done; push_frame(16'hFFFF); send(16'hFFFF); wait_done(d0 + 1); compare_frames("fFFFF");
    check("no_overrun_yet", 32'(overrun), 32'd0);

    // Two strobes during a frame: the newer one wins, overrun sets, exactly two frames
    d0 = n_done; base = n_start;
    push_frame(16'h0BAD); push_frame(16'h0002);
    send(16'h0BAD);
    wait_starts(base + 2);
    send(16'h0001);
    repeat (4) @(negedge clk);
    send(16'h0002);
    wait_done(d0 + 2);
    compare_frames("ovr");
    check("overrun_set", 32'(overrun), 32'd1);
    repeat (300) @(negedge clk);
    check("two_frames_only", 32'(n_start - base), 32'd10);

    // A strobe in the DONE cycle becomes the next frame
    d0 = n_done;
    push_frame(16'hC0DE); push_frame(16'h7E57);
    send(16'hC0DE);
    c = 0;
    while (!frame_done && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(frame_done), 32'd1);
    data_in    = 16'h7E57;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_done(d0 + 2);
    compare_frames("donecap");

    // Transmitter never acknowledges: each byte advances on the ack timeout
    busy_en = 1'b0;
    s1 = 16'($urandom);
    d0 = n_done; push_frame(s1); send(s1); wait_done(d0 + 1); compare_frames("ackto");
    busy_en = 1'b1;

    // Reset during byte 3 aborts the frame and nothing restarts on its own
    base = n_start;
    send(16'h5A5A);
    wait_starts(base + 3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_start;
    repeat (300) @(negedge clk);
    check("no_start_after_rst", 32'(n_start - base), 32'd0);
    s1 = 16'($urandom);
    d0 = n_done; push_frame(s1); send(s1); wait_done(d0 + 1); compare_frames("postrst");

    // Random samples with 0, 1 or 2 extra strobes landing mid-frame
    ov_exp = 1'b0;
    for (int it = 0; it < 8; it++) begin
      k    = $urandom_range(1, 3);
      s1   = 16'($urandom);
      sk   = s1;
      d0   = n_done;
      base = n_start;
      nf   = 1;
      push_frame(s1);
      send(s1);
      if (k > 1) begin
        wait_starts(base + 2);
        for (int j = 2; j <= k; j++) begin
          repeat ($urandom_range(1, 6)) @(negedge clk);
          sk = 16'($urandom);
          send(sk);
        end
        push_frame(sk);
        nf = 2;
        if (k == 3) ov_exp = 1'b1;
      end
      wait_done(d0 + nf);
      repeat (3) @(negedge clk);
      check("rand_idle_fbusy", 32'(frame_busy), 32'd0);
      compare_frames($sformatf("rand%0d", it));
      check("rand_overrun", 32'(overrun), 32'(ov_exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
